mem_read_unit: RTL and testbench
================================

// Module: mem_read_unit
// PURPOSE
//  Read side of the MEM stage: takes a load from the pipeline and issues it to a
//  variable-latency data memory (request/ack, then read-valid). Holds the pipeline
//  stalled until data returns, then presents it to the MEM/WB register for one
//  cycle. Handles flush and a response timeout.
// PARAMETERS
//  ADDR_W   16   address width
//  DATA_W   16   data width
//  TIMEOUT  64   max cycles in WAIT before an error response (>=2)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       reset, asynchronous, active-low
//  req_valid  in   1       load present in MEM stage
//  req_addr   in   ADDR_W  load address
//  flush      in   1       squash the in-flight load
//  stall      out  1       hold IF..MEM stages this cycle
//  rd_valid   out  1       rd_data valid (one-cycle pulse)
//  rd_data    out  DATA_W  load result
//  rd_err     out  1       timeout flag, qualified by rd_valid
//  mem_req    out  1       read request to memory
//  mem_addr   out  ADDR_W  request address
//  mem_ack    in   1       memory accepted mem_req this cycle
//  mem_rvalid in   1       mem_rdata valid this cycle
//  mem_rdata  in   DATA_W  read data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0. Outputs: mem_req=0, mem_addr=0,
//   rd_valid=0, rd_data=0, rd_err=0. stall=0.
//  FSM states:
//   IDLE  -> REQ   on req_valid && !flush; latch req_addr into mem_addr.
//   REQ   mem_req=1 (mem_addr held).
//         -> IDLE  on flush && !mem_ack (request dropped).
//         -> DRAIN on flush && mem_ack && !mem_rvalid.
//         -> IDLE  on flush && mem_ack && mem_rvalid (data discarded).
//         -> RESP  on mem_ack && mem_rvalid (same-cycle data).
//         -> WAIT  on mem_ack.
//   WAIT  counter += 1 per cycle.
//         -> DRAIN on flush && !mem_rvalid.
//         -> IDLE  on flush && mem_rvalid.
//         -> RESP  on mem_rvalid: rd_data<=mem_rdata, rd_err<=0.
//         -> RESP  when counter reaches TIMEOUT-1 with no rvalid: rd_data<=0,
//            rd_err<=1.
//   DRAIN -> IDLE  on mem_rvalid (data discarded). Ignores req_valid. No timeout.
//   RESP  rd_valid=1, stall=0 for exactly one cycle; -> IDLE. req_valid ignored
//         (it is the completing load).
//   Counter clears on every entry to WAIT.
//  stall = REQ | WAIT | DRAIN | (IDLE & req_valid & !flush). Combinational.
//  rd_data and rd_err are registered and hold until the next RESP.
//  rd_valid and mem_req are driven from state; no combinational path from
//   mem_* inputs to mem_req.
//  mem_rvalid outside WAIT, DRAIN, or REQ-with-ack is ignored.
//  Latency (accept cycle = c0): best case rd_valid in c2 (ack+rvalid in c1);
//   otherwise the RESP cycle follows the rvalid cycle.
//  Only one outstanding read; memory returns in order.
//  Reset mid-operation: FSM returns to IDLE immediately. The memory side must
//   also be reset.
// TESTING
//  1 req_valid, addr=0x0040; ack c1, rvalid c1 data=0xBEEF -> rd_valid c2,
//    rd_data=0xBEEF, stall=1 c0..c1 and 0 c2.
//  2 ack c1, rvalid c5 data=0x1234 -> mem_req=1 only c1, stall c0..c5,
//    rd_valid c6 with 0x1234, rd_err=0.
//  3 ack c1, no rvalid (TIMEOUT=64) -> rd_valid with rd_err=1, rd_data=0
//    exactly TIMEOUT cycles after WAIT entry.
//  4 flush in WAIT, rvalid 3 cycles later, new req_valid meanwhile -> no
//    rd_valid; stall held; new mem_req only after DRAIN->IDLE.
//  5 flush in REQ without ack -> IDLE next cycle, mem_req drops, no rd_valid.
//  6 rst=0 asserted mid-WAIT, between edges -> all outputs 0 immediately;
//    after release a new load completes normally.

Source files
------------

// File: rtl/mem_read_unit_if.sv
// Memory read port between the MEM-stage read unit (master) and the data memory (slave).
// Request/ack issue phase followed by a separate read-valid return phase.
interface mem_read_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/mem_read_unit.sv
// MEM-stage load unit: issues one load to a variable-latency memory, stalls the
// pipeline until data (or a timeout) returns, then pulses the result for one cycle.
module mem_read_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              stall,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    mem_read_unit_if.master   mem
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_e;

    state_e             r_state;
    state_e             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_err;
    logic               w_timeout;
    logic               w_stall;
    logic               w_mem_req;
    logic               w_rd_valid;

    assign w_timeout = (r_count == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first so no path through the case leaves a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid && !flush) w_next_state = S_REQ;
            end
            S_REQ: begin
                if (flush) begin
                    w_next_state = (mem.mem_ack && !mem.mem_rvalid) ? S_DRAIN : S_IDLE;
                end else if (mem.mem_ack) begin
                    w_next_state = mem.mem_rvalid ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_next_state = mem.mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem.mem_rvalid || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            // An acked read that was flushed still returns data; swallow it here.
            S_DRAIN: begin
                if (mem.mem_rvalid) w_next_state = S_IDLE;
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall    = 1'b0;
        w_mem_req  = 1'b0;
        w_rd_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_stall    = req_valid && !flush;
            S_REQ:   begin
                w_stall   = 1'b1;
                w_mem_req = 1'b1;
            end
            S_WAIT:  w_stall    = 1'b1;
            S_DRAIN: w_stall    = 1'b1;
            S_RESP:  w_rd_valid = 1'b1;
            default: ;
        endcase
    end

    // Counter runs only while waiting, so it is zero on every entry to WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_state != S_WAIT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr <= '0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_next_state == S_REQ) begin
                r_mem_addr <= req_addr;
            end
            // Entering RESP without rvalid can only mean the WAIT timeout fired.
            if (w_next_state == S_RESP) begin
                r_rd_data <= mem.mem_rvalid ? mem.mem_rdata : '0;
                r_rd_err  <= !mem.mem_rvalid;
            end
        end
    end

    assign stall        = w_stall;
    assign rd_valid     = w_rd_valid;
    assign rd_data      = r_rd_data;
    assign rd_err       = r_rd_err;
    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = r_mem_addr;

endmodule

// File: tb/tb_mem_read_unit.sv
// Directed bench for mem_read_unit: a per-cycle vector table for the common flows,
// plus hand-written timeout and mid-transaction reset sequences.
module tb_mem_read_unit;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              stall;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

    mem_read_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    mem_read_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .flush    (flush),
        .stall    (stall),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in_ctl;   // {req_valid, flush, mem_ack, mem_rvalid}
        logic [15:0] addr;
        logic [15:0] rdata;
        logic [2:0]  exp_ctl;  // {stall, mem_req, rd_valid}
        logic [15:0] exp_maddr;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vq[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] in_ctl, input logic [15:0] addr, input logic [15:0] rdata,
                       input logic [2:0] exp_ctl, input logic [15:0] exp_maddr,
                       input logic [15:0] exp_rd, input logic exp_err);
        vec_t v;
        v.in_ctl    = in_ctl;
        v.addr      = addr;
        v.rdata     = rdata;
        v.exp_ctl   = exp_ctl;
        v.exp_maddr = exp_maddr;
        v.exp_rd    = exp_rd;
        v.exp_err   = exp_err;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic fl, input logic ack, input logic rvld,
                         input logic [15:0] addr, input logic [15:0] rdata);
        req_valid          = rv;
        flush              = fl;
        mem_bus.mem_ack    = ack;
        mem_bus.mem_rvalid = rvld;
        req_addr           = addr;
        mem_bus.mem_rdata  = rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n_wait;
        bit  found;

        // Load 0x0040, ack+rvalid together: best-case latency.
        add(4'b1000, 16'h0040, 16'h0000, 3'b100, 16'h0000, 16'h0000, 1'b0);
        add(4'b1011, 16'h0040, 16'hBEEF, 3'b110, 16'h0040, 16'h0000, 1'b0);
        add(4'b1000, 16'h0040, 16'h0000, 3'b001, 16'h0040, 16'hBEEF, 1'b0);
        add(4'b0000, 16'h0000, 16'h0000, 3'b000, 16'h0040, 16'hBEEF, 1'b0);
        // Load 0x0200, ack c1, rvalid c5.
        add(4'b1000, 16'h0200, 16'h0000, 3'b100, 16'h0040, 16'hBEEF, 1'b0);
        add(4'b1010, 16'h0200, 16'h0000, 3'b110, 16'h0200, 16'hBEEF, 1'b0);
        add(4'b1000, 16'h0200, 16'h0000, 3'b100, 16'h0200, 16'hBEEF, 1'b0);
        add(4'b1000, 16'h0200, 16'h0000, 3'b100, 16'h0200, 16'hBEEF, 1'b0);
        add(4'b1000, 16'h0200, 16'h0000, 3'b100, 16'h0200, 16'hBEEF, 1'b0);
        add(4'b1001, 16'h0200, 16'h1234, 3'b100, 16'h0200, 16'hBEEF, 1'b0);
        add(4'b1000, 16'h0200, 16'h0000, 3'b001, 16'h0200, 16'h1234, 1'b0);
        // Stray rvalid in IDLE is ignored.
        add(4'b0001, 16'h0000, 16'hDEAD, 3'b000, 16'h0200, 16'h1234, 1'b0);
        // Flush in REQ without ack.
        add(4'b1000, 16'h0300, 16'h0000, 3'b100, 16'h0200, 16'h1234, 1'b0);
        add(4'b0100, 16'h0000, 16'h0000, 3'b110, 16'h0300, 16'h1234, 1'b0);
        add(4'b0000, 16'h0000, 16'h0000, 3'b000, 16'h0300, 16'h1234, 1'b0);
        // req_valid with flush in IDLE is not accepted.
        add(4'b1100, 16'h0310, 16'h0000, 3'b000, 16'h0300, 16'h1234, 1'b0);
        add(4'b0000, 16'h0000, 16'h0000, 3'b000, 16'h0300, 16'h1234, 1'b0);
        // Flush in WAIT, drain 3 cycles later while a new load waits.
        add(4'b1000, 16'h0400, 16'h0000, 3'b100, 16'h0300, 16'h1234, 1'b0);
        add(4'b1010, 16'h0400, 16'h0000, 3'b110, 16'h0400, 16'h1234, 1'b0);
        add(4'b0100, 16'h0000, 16'h0000, 3'b100, 16'h0400, 16'h1234, 1'b0);
        add(4'b1000, 16'h0500, 16'h0000, 3'b100, 16'h0400, 16'h1234, 1'b0);
        add(4'b1000, 16'h0500, 16'h0000, 3'b100, 16'h0400, 16'h1234, 1'b0);
        add(4'b1001, 16'h0500, 16'h5555, 3'b100, 16'h0400, 16'h1234, 1'b0);
        add(4'b1000, 16'h0500, 16'h0000, 3'b100, 16'h0400, 16'h1234, 1'b0);
        add(4'b1011, 16'h0500, 16'h0A0A, 3'b110, 16'h0500, 16'h1234, 1'b0);
        add(4'b1000, 16'h0500, 16'h0000, 3'b001, 16'h0500, 16'h0A0A, 1'b0);
        add(4'b0000, 16'h0000, 16'h0000, 3'b000, 16'h0500, 16'h0A0A, 1'b0);
        // Flush in REQ with ack+rvalid: data discarded.
        add(4'b1000, 16'h0600, 16'h0000, 3'b100, 16'h0500, 16'h0A0A, 1'b0);
        add(4'b0111, 16'h0000, 16'hFFFF, 3'b110, 16'h0600, 16'h0A0A, 1'b0);
        add(4'b0000, 16'h0000, 16'h0000, 3'b000, 16'h0600, 16'h0A0A, 1'b0);

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check1 ("reset.stall",    stall,            1'b0);
        check1 ("reset.mem_req",  mem_bus.mem_req,  1'b0);
        check16("reset.mem_addr", mem_bus.mem_addr, 16'h0000);
        check1 ("reset.rd_valid", rd_valid,         1'b0);
        check16("reset.rd_data",  rd_data,          16'h0000);
        check1 ("reset.rd_err",   rd_err,           1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vq[i].in_ctl[3], vq[i].in_ctl[2], vq[i].in_ctl[1], vq[i].in_ctl[0],
                  vq[i].addr, vq[i].rdata);
            @(negedge clk);
            check1 ($sformatf("vec%0d.stall", i),    stall,            vq[i].exp_ctl[2]);
            check1 ($sformatf("vec%0d.mem_req", i),  mem_bus.mem_req,  vq[i].exp_ctl[1]);
            check1 ($sformatf("vec%0d.rd_valid", i), rd_valid,         vq[i].exp_ctl[0]);
            check16($sformatf("vec%0d.mem_addr", i), mem_bus.mem_addr, vq[i].exp_maddr);
            check16($sformatf("vec%0d.rd_data", i),  rd_data,          vq[i].exp_rd);
            check1 ($sformatf("vec%0d.rd_err", i),   rd_err,           vq[i].exp_err);
        end

        // Timeout: ack but never rvalid.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0000);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0700, 16'h0000);
        @(negedge clk);
        check1 ("tmo.mem_req",  mem_bus.mem_req,  1'b1);
        check16("tmo.mem_addr", mem_bus.mem_addr, 16'h0700);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0000);
        n_wait = 0;
        found  = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (rd_valid) begin
                found = 1'b1;
            end else begin
                n_wait++;
                @(posedge clk); #1;
            end
        end
        check1 ("tmo.rd_valid_seen", found, 1'b1);
        check16("tmo.wait_cycles", 16'(n_wait), 16'(TIMEOUT));
        check1 ("tmo.rd_err",  rd_err,  1'b1);
        check16("tmo.rd_data", rd_data, 16'h0000);
        check1 ("tmo.stall",   stall,   1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check1 ("tmo.rd_valid_drop", rd_valid, 1'b0);
        check1 ("tmo.rd_err_hold",   rd_err,   1'b1);

        // Async reset in the middle of WAIT.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0800, 16'h0000);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000);
        @(negedge clk);
        check1 ("rstw.pre_stall",    stall,            1'b1);
        check16("rstw.pre_mem_addr", mem_bus.mem_addr, 16'h0800);
        #2;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        check1 ("rstw.stall",    stall,            1'b0);
        check1 ("rstw.mem_req",  mem_bus.mem_req,  1'b0);
        check16("rstw.mem_addr", mem_bus.mem_addr, 16'h0000);
        check1 ("rstw.rd_valid", rd_valid,         1'b0);
        check16("rstw.rd_data",  rd_data,          16'h0000);
        check1 ("rstw.rd_err",   rd_err,           1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0900, 16'h0000);
        @(negedge clk);
        check1 ("post.stall_c0", stall, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0900, 16'hC0DE);
        @(negedge clk);
        check1 ("post.mem_req",  mem_bus.mem_req,  1'b1);
        check16("post.mem_addr", mem_bus.mem_addr, 16'h0900);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0900, 16'h0000);
        @(negedge clk);
        check1 ("post.rd_valid", rd_valid, 1'b1);
        check16("post.rd_data",  rd_data,  16'hC0DE);
        check1 ("post.rd_err",   rd_err,   1'b0);
        check1 ("post.stall_c2", stall,    1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check1 ("post.rd_valid_drop", rd_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
